// File: rtl/aud_cic_pkg.sv
// Shared definitions for the audio CIC interpolator and decimator.
//   CIC_STAGES   : number of comb / integrator stages
//   COUNTER_BITS : width of the phase counter
//   sat_shift()  : arithmetic right shift followed by two's-complement saturation
package aud_cic_pkg;

    localparam int unsigned CIC_STAGES   = 5;
    localparam int unsigned COUNTER_BITS = 16;
    localparam int unsigned SAT_CALC_W   = 64;

    // Shift value right arithmetically, then clamp it to a signed 'bits'-wide range.
    // The result is returned at full calculation width.
    // Callers keep only the low 'bits' bits.
    function automatic logic signed [SAT_CALC_W-1:0] sat_shift(
        input logic signed [SAT_CALC_W-1:0] value,
        input int unsigned                  shift,
        input int unsigned                  bits
    );
        logic signed [SAT_CALC_W-1:0] shifted;
        logic signed [SAT_CALC_W-1:0] max_v;
        logic signed [SAT_CALC_W-1:0] min_v;
        logic signed [SAT_CALC_W-1:0] result;
        shifted = value >>> shift;
        max_v   = $signed((SAT_CALC_W'(1) << (bits - 1)) - SAT_CALC_W'(1));
        min_v   = -max_v - SAT_CALC_W'(1);
        if (shifted > max_v) begin
            result = max_v;
        end else if (shifted < min_v) begin
            result = min_v;
        end else begin
            result = shifted;
        end
        return result;
    endfunction

endpackage

// File: rtl/aud_cic_sat.sv
// Combinational shift-and-saturate stage shared by the CIC interpolator/decimator.
//   din    : WIDTH-bit signed integrator value
//   shift  : arithmetic right-shift amount
//   dout_c : BITS-bit signed saturated result (combinational)
module aud_cic_sat
    import aud_cic_pkg::*;
#(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned BITS  = 16
) (
    input  logic signed [WIDTH-1:0] din,
    input  logic        [31:0]      shift,
    output logic signed [BITS-1:0]  dout_c
);

    assign dout_c = BITS'(sat_shift(SAT_CALC_W'(din), shift, BITS));

endmodule

// File: rtl/aud_cic_interp.sv
// Five-stage CIC interpolator: comb at the low rate, zero-stuff, integrate at the
// high rate, then apply the programmable shift and saturate.
//   CLK, RSTb   : clock, asynchronous active-low reset
//   hs_tick     : high-rate sample strobe (one cycle wide, >= 2 cycles apart)
//   x_in        : low-rate signed input, taken on capture ticks (phase 0)
//   gain        : output gain; shift = OUT_SHIFT - gain, clamped at 0
//   sample_req  : pulse in the cycle after each capture tick
//   x_out       : high-rate signed output sample
//   out_tick    : pulse in the cycle after each hs_tick (x_out updated)
module aud_cic_interp
    import aud_cic_pkg::*;
#(
    parameter int unsigned WIDTH     = 40,
    parameter int unsigned INTERP    = 20,
    parameter int unsigned BITS      = 16,
    parameter int unsigned GAIN_BITS = 8,
    parameter int unsigned OUT_SHIFT = 17
) (
    input  logic                        CLK,
    input  logic                        RSTb,
    input  logic                        hs_tick,
    input  logic signed [BITS-1:0]      x_in,
    input  logic        [GAIN_BITS-1:0] gain,
    output logic                        sample_req,
    output logic signed [BITS-1:0]      x_out,
    output logic                        out_tick
);

    logic        [COUNTER_BITS-1:0] count;
    logic signed [WIDTH-1:0]        comb_q  [CIC_STAGES];
    logic signed [WIDTH-1:0]        dly_q   [CIC_STAGES];
    logic signed [WIDTH-1:0]        integ_q [CIC_STAGES];

    logic                           capture_c;
    logic signed [WIDTH-1:0]        x_ext_c;
    logic signed [WIDTH-1:0]        stuff_c;
    logic        [31:0]             shift_c;
    logic signed [BITS-1:0]         sat_c;

    assign capture_c = hs_tick && (count == '0);
    assign x_ext_c   = WIDTH'(x_in);
    // Zero-stuffing: only capture ticks feed the comb output into the integrators.
    assign stuff_c   = capture_c ? comb_q[CIC_STAGES-1] : '0;
    assign shift_c   = (32'(gain) <= 32'(OUT_SHIFT)) ? (32'(OUT_SHIFT) - 32'(gain)) : 32'd0;

    aud_cic_sat #(
        .WIDTH (WIDTH),
        .BITS  (BITS)
    ) u_sat (
        .din    (integ_q[CIC_STAGES-1]),
        .shift  (shift_c),
        .dout_c (sat_c)
    );

    // Phase counter; phase 0 marks the capture tick.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            count <= '0;
        end else if (hs_tick) begin
            count <= (count == COUNTER_BITS'(INTERP - 1)) ? '0 : count + 1'b1;
        end
    end

    // Comb pipeline: each stage differences the previous stage's old output.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            for (int k = 0; k < CIC_STAGES; k++) begin
                comb_q[k] <= '0;
                dly_q[k]  <= '0;
            end
        end else if (capture_c) begin
            comb_q[0] <= x_ext_c - dly_q[0];
            dly_q[0]  <= x_ext_c;
            for (int k = 1; k < CIC_STAGES; k++) begin
                comb_q[k] <= comb_q[k-1] - dly_q[k];
                dly_q[k]  <= comb_q[k-1];
            end
        end
    end

    // Integrator chain; wraps modulo 2^WIDTH by design.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            for (int k = 0; k < CIC_STAGES; k++) begin
                integ_q[k] <= '0;
            end
        end else if (hs_tick) begin
            integ_q[0] <= integ_q[0] + stuff_c;
            for (int k = 1; k < CIC_STAGES; k++) begin
                integ_q[k] <= integ_q[k] + integ_q[k-1];
            end
        end
    end

    // Output register and strobes.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            x_out      <= '0;
            out_tick   <= 1'b0;
            sample_req <= 1'b0;
        end else begin
            out_tick   <= hs_tick;
            sample_req <= capture_c;
            if (hs_tick) begin
                x_out <= sat_c;
            end
        end
    end

endmodule
